// File: rtl/md_hilo_sched.sv
// md_hilo_sched -- E-stage multiply/divide sequencer and owner of the
// architectural HI/LO registers.
//
// It accepts one HI/LO-class op per cycle from the E stage through a
// valid/ready handshake. A mult/div op latches its operands and launches the
// external datapath with a one-cycle start pulse. The block then counts that
// op's fixed latency and writes the datapath result into HI/LO. A divide by
// zero still takes the full latency, but it leaves HI/LO unchanged. mthi/mtlo
// write HI/LO directly. mfhi/mflo read them combinationally.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   op_valid/op_ready E-stage handshake (ready only while idle)
//   op_type           0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi,
//                     6 mtlo, 7 mfhi, 8 mflo, 9..15 none
//   op_a, op_b        rs / rt operand values
//   d_hilo_use        D-stage instruction uses HI/LO or the mult/div unit
//   stall             freeze D and bubble E while an operation is pending
//   dp_start          one-cycle launch pulse to the datapath
//   dp_signed/is_div  operation kind, held while busy
//   dp_a, dp_b        latched operands, held while busy
//   dp_hi, dp_lo      datapath result, sampled on the commit edge
//   mf_result         HI or LO for an accepted mfhi/mflo, else 0
//   busy              a mult/div operation is in flight
module md_hilo_sched #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  op_type,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        op_ready,
  input  logic        d_hilo_use,
  output logic        stall,
  output logic        dp_start,
  output logic        dp_signed,
  output logic        dp_is_div,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  input  logic [31:0] dp_hi,
  input  logic [31:0] dp_lo,
  output logic [31:0] mf_result,
  output logic        busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  // The counter is preloaded with LAT-1 and is checked for zero while in RUN,
  // so the commit lands exactly LAT edges after the accept edge.
  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT - 1);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT - 1);

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;   // pending divide has a zero divisor: skip the commit

  logic accept;
  logic md_issue;
  logic issue_signed;
  logic issue_div;

  // NOTE: give every always_comb output a default at the top, so that no path
  // through the block leaves a signal unassigned and infers a latch.
  always_comb begin
    op_ready     = (state == IDLE);
    accept       = 1'b0;
    md_issue     = 1'b0;
    issue_signed = 1'b0;
    issue_div    = 1'b0;
    mf_result    = 32'd0;

    if (op_valid && op_ready && op_type >= OP_MULT && op_type <= OP_MFLO)
      accept = 1'b1;

    if (accept && op_type <= OP_DIVU)
      md_issue = 1'b1;

    issue_signed = (op_type == OP_MULT) || (op_type == OP_DIV);
    issue_div    = (op_type == OP_DIV)  || (op_type == OP_DIVU);

    if (accept && op_type == OP_MFHI)
      mf_result = hi;
    else if (accept && op_type == OP_MFLO)
      mf_result = lo;
  end

  assign busy  = (state == RUN);
  // Stall also covers the issue cycle itself. In that cycle the state is still
  // IDLE, but the D-stage instruction must wait for the new result.
  assign stall = d_hilo_use & (busy | md_issue);

  // NOTE: sequential state is updated with non-blocking assignments only. All
  // registers then see the values from before the edge, whatever the
  // statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      dp_a      <= 32'd0;
      dp_b      <= 32'd0;
      dp_signed <= 1'b0;
      dp_is_div <= 1'b0;
      dp_start  <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      dp_start <= md_issue;

      case (state)
        IDLE: begin
          if (md_issue) begin
            dp_a      <= op_a;
            dp_b      <= op_b;
            dp_signed <= issue_signed;
            dp_is_div <= issue_div;
            div_zero  <= issue_div && (op_b == 32'd0);
            cnt       <= issue_div ? DIV_CNT : MULT_CNT;
            state     <= RUN;
          end else if (accept && op_type == OP_MTHI) begin
            hi <= op_a;
          end else if (accept && op_type == OP_MTLO) begin
            lo <= op_a;
          end
        end

        RUN: begin
          if (cnt == 4'd0) begin
            if (!div_zero) begin
              hi <= dp_hi;
              lo <= dp_lo;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
